nibble_serial_adder: RTL and testbench

//  Sequencer that drives the 4-bit ripple adder (fadd chain), one nibble per clock.

---
 rtl/nibble_serial_adder.sv | 135 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Sequencer that feeds an external combinational 4-bit adder one nibble per clock
// and returns a WIDTH-bit add/sub result over a valid/ready handshake.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_c,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;
  logic [WIDTH-1:0]   r_sum, w_sum_nxt;
  logic               r_carry, w_carry_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_in_ready, r_out_valid;
  logic [3:0]         r_add_a, r_add_b, w_add_a_nxt, w_add_b_nxt;
  logic               r_add_cin, w_add_cin_nxt;

  // Next-state and datapath update; the adder result is only consumed in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    w_idx_nxt   = r_idx;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a_nxt     = in_a;
          w_b_nxt     = in_sub ? ~in_b : in_b;
          w_carry_nxt = in_sub ? 1'b1 : in_cin;
          w_idx_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_sum_nxt[4*r_idx +: 4] = add_c;
        w_carry_nxt             = add_cout;
        if (r_idx == IDX_W'(N - 1)) begin
          // Final nibble: add_c[3] is the result MSB.
          w_ovf_nxt   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_c[3] != r_a[WIDTH-1]);
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Adder operands are registered one cycle ahead from the next-state values.
  always_comb begin
    w_add_a_nxt   = 4'd0;
    w_add_b_nxt   = 4'd0;
    w_add_cin_nxt = 1'b0;
    if (w_state_nxt == RUN) begin
      w_add_a_nxt   = w_a_nxt[4*w_idx_nxt +: 4];
      w_add_b_nxt   = w_b_nxt[4*w_idx_nxt +: 4];
      w_add_cin_nxt = w_carry_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_add_a     <= 4'd0;
      r_add_b     <= 4'd0;
      r_add_cin   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_sum       <= w_sum_nxt;
      r_carry     <= w_carry_nxt;
      r_idx       <= w_idx_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_add_a     <= w_add_a_nxt;
      r_add_b     <= w_add_b_nxt;
      r_add_cin   <= w_add_cin_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;
  assign out_ovf   = r_ovf;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) with a behavioural 4-bit adder.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_c;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // External combinational nibble adder
  assign {add_cout, add_c} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_c(add_c), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full transaction; lat = cycles from accept edge to out_valid (99 = never accepted).
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sub, input logic cin,
                       output int lat, output logic [WIDTH-1:0] sum,
                       output logic cout, output logic ovf);
    int w;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    sum = '0; cout = 1'b0; ovf = 1'b0;
    if (!in_ready) begin
      lat = 99;
      in_valid = 1'b0;
    end else begin
      step();
      in_valid = 1'b0;
      in_a = 16'hDEAD; in_b = 16'hBEEF;
      lat = 0;
      while (!out_valid && lat < 20) begin step(); lat++; end
      sum = out_sum; cout = out_cout; ovf = out_ovf;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_sum !== 16'h0000 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got sum=%h cout=%0b ovf=%0b want 0/0/0", out_sum, out_cout, out_ovf); end
    n_cmp++; if ({add_a, add_b, add_cin} !== 9'd0) begin
      n_fail++; $display("FAIL reset_add_bus got a=%h b=%h cin=%0b want 0", add_a, add_b, add_cin); end
  endtask

  task automatic test_add();
    int lat; logic [WIDTH-1:0] s; logic c, v;
    // First RUN cycle presents nibble 0 of each operand
    in_a = 16'h1234; in_b = 16'h0FFF; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (add_a !== 4'h4 || add_b !== 4'hF || add_cin !== 1'b0) begin
      n_fail++; $display("FAIL add_first_nibble got a=%h b=%h cin=%0b want 4/f/0", add_a, add_b, add_cin); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_run_ready got %0b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL add_latency got %0d want 4", lat); end
    n_cmp++; if (out_sum !== 16'h2233 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL add_1234_0fff got %h/%0b/%0b want 2233/0/0", out_sum, out_cout, out_ovf); end
    n_cmp++; if ({add_a, add_b, add_cin} !== 9'd0) begin
      n_fail++; $display("FAIL add_bus_done got a=%h b=%h cin=%0b want 0", add_a, add_b, add_cin); end
    out_ready = 1'b1; step(); out_ready = 1'b0;

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, c, v);
    n_cmp++; if (s !== 16'h0000 || c !== 1'b1 || v !== 1'b0 || lat != 4) begin
      n_fail++; $display("FAIL add_ripple got %h/%0b/%0b lat %0d want 0000/1/0 lat 4", s, c, v, lat); end

    do_op(16'h00FF, 16'h0F00, 1'b0, 1'b1, lat, s, c, v);
    n_cmp++; if (s !== 16'h1000 || c !== 1'b0 || v !== 1'b0) begin
      n_fail++; $display("FAIL add_cin got %h/%0b/%0b want 1000/0/0", s, c, v); end
  endtask

  task automatic test_sub();
    int lat; logic [WIDTH-1:0] s; logic c, v;
    // cin must be ignored when subtracting
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0, lat, s, c, v);
    n_cmp++; if (s !== 16'hFFFE || c !== 1'b0 || v !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow got %h/%0b/%0b want fffe/0/0", s, c, v); end
    do_op(16'h0009, 16'h0003, 1'b1, 1'b0, lat, s, c, v);
    n_cmp++; if (s !== 16'h0006 || c !== 1'b1 || v !== 1'b0) begin
      n_fail++; $display("FAIL sub_noborrow got %h/%0b/%0b want 0006/1/0", s, c, v); end
  endtask

  task automatic test_overflow();
    int lat; logic [WIDTH-1:0] s; logic c, v;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, s, c, v);
    n_cmp++; if (s !== 16'h8000 || c !== 1'b0 || v !== 1'b1) begin
      n_fail++; $display("FAIL ovf_add got %h/%0b/%0b want 8000/0/1", s, c, v); end
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, lat, s, c, v);
    n_cmp++; if (s !== 16'h7FFF || c !== 1'b1 || v !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sub got %h/%0b/%0b want 7fff/1/1", s, c, v); end
  endtask

  task automatic test_backpressure();
    int lat;
    in_a = 16'hA5C3; in_b = 16'h1111; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    step();
    // Next operand is already waiting while the first is in flight
    in_a = 16'h0100; in_b = 16'h0200;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_sum !== 16'hB6D4 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%0b sum=%h c=%0b rdy=%0b want 1/b6d4/0/0",
                           i, out_valid, out_sum, out_cout, in_ready); end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got rdy=%0b v=%0b want 1/0", in_ready, out_valid); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0) begin
      n_fail++; $display("FAIL bp_accept got rdy=%0b a=%h b=%h want 0/0/0", in_ready, add_a, add_b); end
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    n_cmp++; if (out_sum !== 16'h0300 || lat != 4) begin
      n_fail++; $display("FAIL bp_second got %h lat %0d want 0300 lat 4", out_sum, lat); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int lat; logic [WIDTH-1:0] s; logic c, v;
    in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_cmp++; if (add_a !== 4'h1 || add_b !== 4'h2) begin
      n_fail++; $display("FAIL rst_mid_idx2 got a=%h b=%h want 1/2", add_a, add_b); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0000 || add_a !== 4'h0) begin
      n_fail++; $display("FAIL rst_mid_state got rdy=%0b v=%0b sum=%h a=%h want 1/0/0000/0",
                         in_ready, out_valid, out_sum, add_a); end
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, s, c, v);
    n_cmp++; if (s !== 16'h0002 || c !== 1'b0 || v !== 1'b0 || lat != 4) begin
      n_fail++; $display("FAIL rst_mid_next got %h/%0b/%0b lat %0d want 0002/0/0 lat 4", s, c, v, lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_a = 16'h0001; in_b = 16'h0002; in_sub = 1'b0; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 4) begin
        n_cmp++; if (out_valid !== 1'b1 || out_sum !== 16'h0003) begin
          n_fail++; $display("FAIL b2b_first got v=%0b sum=%h want 1/0003", out_valid, out_sum); end
      end
      if (c == 5) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got %0b want 1", in_ready); end
      end
    end
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_spacing got rdy=%0b v=%0b want 0/0", in_ready, out_valid); end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    n_cmp++; if (out_sum !== 16'h0003 || lat != 4) begin
      n_fail++; $display("FAIL b2b_second got %h lat %0d want 0003 lat 4", out_sum, lat); end
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
    #1;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
